// File: rtl/synth_spi_regfile.sv
// SPI-slave command decoder and oscillator register bank for the synth.
// Bytes from a synchronised mode-0 front end drive a small FSM; each register is committed atomically.
`timescale 1ns/1ps
module synth_spi_regfile #(
  parameter int N_OSC     = 2,
  parameter int WAVE_W    = 3,
  parameter int FREQ_W    = 24,
  parameter int PHASE_W   = 16,
  parameter int AMP_W     = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                     i_clk50mhz,
  input  logic                     i_rst,
  input  logic                     i_spi_clk,
  input  logic                     i_spi_mosi,
  input  logic                     i_spi_ss,
  output logic                     o_spi_miso,
  output logic [N_OSC*WAVE_W-1:0]  o_wave,
  output logic [N_OSC*FREQ_W-1:0]  o_freq,
  output logic [N_OSC*PHASE_W-1:0] o_phase,
  output logic [N_OSC*AMP_W-1:0]   o_amp,
  output logic [N_OSC-1:0]         o_update,
  output logic                     o_cmd_err,
  output logic                     o_timeout
);
  localparam int FREQ_B = (FREQ_W + 7) / 8;
  localparam int STG_W  = (FREQ_B > 2) ? FREQ_B * 8 : 16;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_COMMIT} state_t;

  // ---------------- SPI front end ----------------
  logic [2:0] sclk_q;
  logic [1:0] ss_q, mosi_q;
  logic       ss_prev_q;
  logic [7:0] rx_q, last_q, tx_q;
  logic [2:0] bit_q;
  logic       bv_q;
  logic       sclk_rise, sclk_fall, ss_n, ss_fall;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign ss_n       = ss_q[1];
  assign ss_fall    = ss_prev_q & ~ss_n;
  assign o_spi_miso = tx_q[7] & ~ss_n;

  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      sclk_q    <= '0;
      ss_q      <= '1;
      mosi_q    <= '0;
      ss_prev_q <= 1'b1;
      rx_q      <= '0;
      last_q    <= '0;
      tx_q      <= '0;
      bit_q     <= '0;
      bv_q      <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], i_spi_clk};
      ss_q      <= {ss_q[0], i_spi_ss};
      mosi_q    <= {mosi_q[0], i_spi_mosi};
      ss_prev_q <= ss_n;
      bv_q      <= 1'b0;
      // Deselect drops any partial byte; the command FSM keeps its state.
      if (ss_n) bit_q <= '0;
      else if (sclk_rise) begin
        rx_q  <= {rx_q[6:0], mosi_q[1]};
        bit_q <= bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          bv_q   <= 1'b1;
          last_q <= {rx_q[6:0], mosi_q[1]};
        end
      end
      if (ss_fall) tx_q <= last_q;
      else if (!ss_n && sclk_fall) tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  // ---------------- command FSM ----------------
  state_t               state_q, state_d;
  logic [3:0]           ch_q, ch_d;
  logic [2:0]           rsel_q, rsel_d, idx_q, idx_d, nb;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d, to_q, to_d, cmd_ok;
  logic [N_OSC*WAVE_W-1:0]  wave_q, wave_d;
  logic [N_OSC*FREQ_W-1:0]  freq_q, freq_d;
  logic [N_OSC*PHASE_W-1:0] phase_q, phase_d;
  logic [N_OSC*AMP_W-1:0]   amp_q, amp_d;

  assign cmd_ok = (int'(last_q[7:4]) < N_OSC) && (last_q[3:0] >= 4'd1) && (last_q[3:0] <= 4'd4);

  always_comb begin
    case (rsel_q)
      3'd1:    nb = 3'd1;
      3'd2:    nb = 3'(FREQ_B);
      default: nb = 3'd2;
    endcase
  end

  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      rsel_q  <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      wave_q  <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rsel_q  <= rsel_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      to_q    <= to_d;
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      amp_q   <= amp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rsel_d  = rsel_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (bv_q && last_q != 8'h00) begin
          if (cmd_ok) begin
            ch_d    = last_q[7:4];
            rsel_d  = last_q[2:0];
            idx_d   = '0;
            stage_d = '0;
            state_d = S_PAYLOAD;
          end else err_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        // A byte arriving on the saturation cycle takes priority over the timeout.
        if (bv_q) begin
          stage_d[{idx_q[1:0], 3'b000} +: 8] = last_q;
          idx_d = idx_q + 3'd1;
          tmo_d = '0;
          if (idx_q + 3'd1 == nb) state_d = S_COMMIT;
        end else if (tmo_q == '1) begin
          to_d    = 1'b1;
          stage_d = '0;
          state_d = S_IDLE;
        end else tmo_d = tmo_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Field write lands on the edge into COMMIT so value and o_update appear together.
  always_comb begin
    wave_d  = wave_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    amp_d   = amp_q;
    if (state_q == S_PAYLOAD && state_d == S_COMMIT) begin
      case (rsel_q)
        3'd1:    wave_d[ch_q*WAVE_W +: WAVE_W]    = stage_d[WAVE_W-1:0];
        3'd2:    freq_d[ch_q*FREQ_W +: FREQ_W]    = stage_d[FREQ_W-1:0];
        3'd3:    phase_d[ch_q*PHASE_W +: PHASE_W] = stage_d[PHASE_W-1:0];
        default: amp_d[ch_q*AMP_W +: AMP_W]       = stage_d[AMP_W-1:0];
      endcase
    end
    o_update = (state_q == S_COMMIT) ? (N_OSC'(1) << ch_q) : '0;
  end

  assign o_wave    = wave_q;
  assign o_freq    = freq_q;
  assign o_phase   = phase_q;
  assign o_amp     = amp_q;
  assign o_cmd_err = err_q;
  assign o_timeout = to_q;
endmodule

// File: tb/tb_synth_spi_regfile.sv
// Randomised scoreboard bench for synth_spi_regfile: transaction-level register model,
// expected pulses/echo bytes queued by the driver and checked by one monitor process.
`timescale 1ns/1ps
module tb_synth_spi_regfile;
  localparam int N_OSC = 2, WAVE_W = 3, FREQ_W = 24, PHASE_W = 16, AMP_W = 16, TIMEOUT_W = 8;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic                     miso;
  logic [N_OSC*WAVE_W-1:0]  o_wave;
  logic [N_OSC*FREQ_W-1:0]  o_freq;
  logic [N_OSC*PHASE_W-1:0] o_phase;
  logic [N_OSC*AMP_W-1:0]   o_amp;
  logic [N_OSC-1:0]         o_update;
  logic                     o_cmd_err, o_timeout;

  synth_spi_regfile #(.N_OSC(N_OSC), .WAVE_W(WAVE_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W),
                      .AMP_W(AMP_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .i_clk50mhz(clk), .i_rst(rst), .i_spi_clk(sclk), .i_spi_mosi(mosi), .i_spi_ss(ss),
    .o_spi_miso(miso), .o_wave(o_wave), .o_freq(o_freq), .o_phase(o_phase), .o_amp(o_amp),
    .o_update(o_update), .o_cmd_err(o_cmd_err), .o_timeout(o_timeout));

  always #10 clk = ~clk;

  typedef struct {
    int                       kind;   // 0 update, 1 cmd_err, 2 timeout
    logic [N_OSC-1:0]         upd;
    logic [N_OSC*WAVE_W-1:0]  wave;
    logic [N_OSC*FREQ_W-1:0]  freq;
    logic [N_OSC*PHASE_W-1:0] phase;
    logic [N_OSC*AMP_W-1:0]   amp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] got_q[$];
  logic [31:0] m_wave[N_OSC], m_freq[N_OSC], m_phase[N_OSC], m_amp[N_OSC];
  logic [7:0] m_last = 8'h00;
  logic       done = 1'b0;
  int checks = 0, errors = 0;

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int nbytes(input int r);
    return (r == 1) ? 1 : (r == 2) ? (FREQ_W + 7) / 8 : 2;
  endfunction

  function automatic bit valid_cmd(input logic [7:0] b);
    return (int'(b[7:4]) < N_OSC) && (b[3:0] >= 4'd1) && (b[3:0] <= 4'd4);
  endfunction

  function automatic exp_t snap(input int kind, input logic [N_OSC-1:0] upd);
    exp_t e;
    e.kind = kind; e.upd = upd;
    for (int k = 0; k < N_OSC; k++) begin
      e.wave[k*WAVE_W +: WAVE_W]    = m_wave[k][WAVE_W-1:0];
      e.freq[k*FREQ_W +: FREQ_W]    = m_freq[k][FREQ_W-1:0];
      e.phase[k*PHASE_W +: PHASE_W] = m_phase[k][PHASE_W-1:0];
      e.amp[k*AMP_W +: AMP_W]       = m_amp[k][AMP_W-1:0];
    end
    return e;
  endfunction

  // One SS-framed transfer as the master; a full byte records what came back on MISO.
  task automatic spi_frame(input logic [7:0] b, input int nbits);
    logic [7:0] rx;
    rx = '0;
    @(negedge clk); ss = 1'b0;
    if (nbits == 8) exp_miso_q.push_back(m_last);
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (5) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    ss = 1'b1;
    if (nbits == 8) begin got_q.push_back(rx); m_last = b; end
    repeat (10) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] v);
    logic [N_OSC-1:0] u;
    u = '0; u[ch] = 1'b1;
    case (r)
      1: m_wave[ch]  = v & msk(WAVE_W);
      2: m_freq[ch]  = v & msk(FREQ_W);
      3: m_phase[ch] = v & msk(PHASE_W);
      default: m_amp[ch] = v & msk(AMP_W);
    endcase
    exp_q.push_back(snap(0, u));
    spi_frame({4'(ch), 4'(r)}, 8);
    for (int i = 0; i < nbytes(r); i++) spi_frame(v[8*i +: 8], 8);
  endtask

  task automatic bad(input logic [7:0] b);
    exp_q.push_back(snap(1, '0));
    spi_frame(b, 8);
  endtask

  task automatic abort(input int ch, input int r, input int k);
    spi_frame({4'(ch), 4'(r)}, 8);
    for (int i = 0; i < k; i++) spi_frame(8'hFF, 8);
    exp_q.push_back(snap(2, '0));
    repeat ((1 << TIMEOUT_W) + 60) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N_OSC; k++) begin
      m_wave[k] = '0; m_freq[k] = '0; m_phase[k] = '0; m_amp[k] = '0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wr(0, 1, 32'h05);
    wr(1, 2, 32'h0007_FFFF);
    wr(1, 4, 32'h7FFF);
    spi_frame(8'h00, 8);
    bad(8'h25);
    bad(8'h06);
    abort(0, 3, 1);
    wr(0, 3, 32'h1234);
    bad(8'hA5);
    spi_frame(8'h3C, 4);
    wr(1, 1, 32'h3);
    for (int t = 0; t < 40; t++) begin
      int sel, r;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      r = $urandom_range(1, 4);
      if (sel <= 5) wr($urandom_range(0, N_OSC-1), r, $urandom);
      else if (sel == 6) begin
        do b = 8'($urandom_range(1, 255)); while (valid_cmd(b));
        bad(b);
      end else if (sel == 7) spi_frame(8'h00, 8);
      else if (sel == 8) abort($urandom_range(0, N_OSC-1), r, $urandom_range(0, nbytes(r)-1));
      else spi_frame(8'($urandom), $urandom_range(1, 7));
    end
    repeat (30) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: run did not complete, got no finish, required finish before 1.8ms");
    $fatal(1);
  end

  initial begin : monitor
    exp_t e;
    logic [7:0] g, x;
    int ss_hi;
    logic [N_OSC*WAVE_W-1:0]  sw;
    logic [N_OSC*FREQ_W-1:0]  sf;
    logic [N_OSC*PHASE_W-1:0] sp;
    logic [N_OSC*AMP_W-1:0]   sa;
    sw = '0; sf = '0; sp = '0; sa = '0; ss_hi = 0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (|o_update || o_cmd_err || o_timeout) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got upd=%b err=%b to=%b, required no pulse", o_update, o_cmd_err, o_timeout);
        end else begin
          e = exp_q.pop_front();
          sw = e.wave; sf = e.freq; sp = e.phase; sa = e.amp;
          if (o_update !== e.upd || o_cmd_err !== (e.kind == 1) || o_timeout !== (e.kind == 2)) begin
            errors++;
            $display("FAIL pulse: got upd=%b err=%b to=%b, required kind=%0d upd=%b", o_update, o_cmd_err, o_timeout, e.kind, e.upd);
          end
        end
      end
      checks++;
      if ({o_wave, o_freq, o_phase, o_amp} !== {sw, sf, sp, sa}) begin
        errors++;
        $display("FAIL regs @%0t: got wave=%h freq=%h phase=%h amp=%h, required wave=%h freq=%h phase=%h amp=%h",
                 $time, o_wave, o_freq, o_phase, o_amp, sw, sf, sp, sa);
      end
      ss_hi = ss ? ss_hi + 1 : 0;
      if (ss_hi >= 4) begin
        checks++;
        if (miso !== 1'b0) begin
          errors++;
          $display("FAIL miso_idle: got %b, required 0 while SS high", miso);
        end
      end
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_miso_q.size() == 0) begin
          errors++;
          $display("FAIL miso_echo: got %h, required no frame", g);
        end else begin
          x = exp_miso_q.pop_front();
          if (g !== x) begin
            errors++;
            $display("FAIL miso_echo: got %h, required %h", g, x);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_pulse: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end
endmodule
